// File: rtl/vc_rand_delay_pkg.sv
// Shared definitions for the rand_delay stall injector: FSM state
// encodings and the default generator seed.
package vc_rand_delay_pkg;

  typedef enum logic [1:0] {
    STATE_LOAD = 2'd0,
    STATE_WAIT = 2'd1,
    STATE_PASS = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  // Clamp a raw delay draw to the configured ceiling.
  function automatic int unsigned clampDelay(input int unsigned raw,
                                             input int unsigned maxDelay);
    return (raw > maxDelay) ? maxDelay : raw;
  endfunction

endpackage

// File: rtl/rand_delay_taus32.sv
// 32-bit Tausworthe pseudo-random register. The state only advances when
// next_p is asserted, so every consumer draw sees a fresh value and idle
// cycles leave the sequence untouched.
module rand_delay_taus32 import vc_rand_delay_pkg::*; #(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset_n_p,
  input  logic        next_p,
  output logic [31:0] rand_np
);

  logic [31:0] rand_q;
  logic [31:0] rand_d;
  logic [31:0] mix;

  // Next generator value: xor-shift right by 17, then xor-shift left by 15.
  always_comb begin
    mix    = (rand_q >> 17) ^ rand_q;
    rand_d = (mix << 15) ^ mix;
  end

  // Generator state register; holds unless a draw is requested.
  always_ff @(posedge clk) begin
    if (!reset_n_p) begin
      rand_q <= SEED;
    end else if (next_p) begin
      rand_q <= rand_d;
    end
  end

  assign rand_np = rand_q;

endmodule

// File: rtl/rand_delay.sv
// Val/rdy stall injector. Each message waits a pseudo-random number of
// cycles (clamped to MAX_DELAY) before it is allowed through; the message
// itself is never stored, only the handshake is gated.
// Optional feature macro: VC_RAND_DELAY_PROTOCOL_CHECK_EN adds a sticky
// err_np output flagging upstream messages that change or vanish while
// stalled.
module rand_delay import vc_rand_delay_pkg::*; #(
  parameter int unsigned MSG_SZ    = 32,
  parameter int unsigned DELAY_SZ  = 4,
  parameter int unsigned MAX_DELAY = 5,
  parameter logic [31:0] SEED      = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset_n_p,
  input  logic [MSG_SZ-1:0] in_msg,
  input  logic              in_val,
  output logic              in_rdy,
  output logic [MSG_SZ-1:0] out_msg,
  output logic              out_val,
  input  logic              out_rdy
`ifdef VC_RAND_DELAY_PROTOCOL_CHECK_EN
  ,
  output logic              err_np
`endif
);

  localparam logic [DELAY_SZ-1:0] MaxDelayW = DELAY_SZ'(MAX_DELAY);
  localparam logic [DELAY_SZ-1:0] CountOne  = DELAY_SZ'(1);

  state_e              state_q;
  state_e              state_d;
  logic [DELAY_SZ-1:0] count_q;
  logic [DELAY_SZ-1:0] count_d;
  logic                drawNext;
  logic [31:0]         randVal;
  logic [DELAY_SZ-1:0] rawDelay;
  logic [DELAY_SZ-1:0] delay;
  logic                unused_randHigh;

  rand_delay_taus32 #(
    .SEED(SEED)
  ) u_taus (
    .clk      (clk),
    .reset_n_p(reset_n_p),
    .next_p   (drawNext),
    .rand_np  (randVal)
  );

  // Only the low DELAY_SZ generator bits form a draw; the rest are folded
  // into a sink so their absence from the datapath is explicit.
  assign unused_randHigh = ^(randVal >> DELAY_SZ);

  // Raw draw from the pre-advance generator value, clamped to the ceiling.
  always_comb begin
    rawDelay = randVal[DELAY_SZ-1:0];
    delay    = (rawDelay > MaxDelayW) ? MaxDelayW : rawDelay;
  end

  assign out_msg = in_msg;

  // Handshake gating and next-state logic; reset low forces the handshake idle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    drawNext = 1'b0;
    out_val  = 1'b0;
    in_rdy   = 1'b0;
    if (reset_n_p) begin
      case (state_q)
        STATE_LOAD: begin
          if (in_val) begin
            drawNext = 1'b1;
            if (delay == '0) begin
              out_val = in_val;
              in_rdy  = out_rdy;
              if (!out_rdy) begin
                state_d = STATE_PASS;
              end
            end else begin
              count_d = delay;
              state_d = (delay == CountOne) ? STATE_PASS : STATE_WAIT;
            end
          end
        end
        STATE_WAIT: begin
          count_d = count_q - CountOne;
          if (count_d == CountOne) begin
            state_d = STATE_PASS;
          end
        end
        STATE_PASS: begin
          out_val = in_val;
          in_rdy  = out_rdy;
          if (in_val && out_rdy) begin
            state_d = STATE_LOAD;
          end
        end
        default: begin
          state_d = STATE_LOAD;
        end
      endcase
    end
  end

  // FSM state and delay counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n_p) begin
      state_q <= STATE_LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef VC_RAND_DELAY_PROTOCOL_CHECK_EN
  logic              err_q;
  logic              err_d;
  logic              stall_q;
  logic [MSG_SZ-1:0] msg_q;

  // A stalled message must stay valid and stable until it is accepted.
  always_comb begin
    err_d = err_q | (stall_q & (~in_val | (in_msg != msg_q)));
  end

  // Remember last cycle's stall condition and message; error is sticky.
  always_ff @(posedge clk) begin
    if (!reset_n_p) begin
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      msg_q   <= '0;
    end else begin
      err_q   <= err_d;
      stall_q <= in_val & ~in_rdy;
      msg_q   <= in_msg;
    end
  end

  assign err_np = err_q;
`endif

endmodule
